// File: rtl/icb_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// icb_rr_arb_pkg
// Purpose : shared ICB bus widths and a small helper for the round-robin
//           arbiter and its owner-tracking FIFO.
// Contents: MEM_ADDR_W (address bus), MEM_DATA_W (data bus), ICB_MASK_W
//           (byte mask), idx_w() giving the width of a master index.
// ----------------------------------------------------------------------------
package icb_rr_arb_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int ICB_MASK_W = 4;

   // A single master still needs a 1-bit index so vectors never collapse to 0 width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icb_rr_arb_fifo.sv
// ----------------------------------------------------------------------------
// icb_rr_arb_fifo
// Purpose : synchronous FIFO holding the master index of every outstanding
//           tracked ICB command, in issue order, so responses can be routed.
// Ports   : clk, rst (async, active-high)
//           push_i/din_i  : write side (ignored when full)
//           pop_i         : read side (ignored when empty)
//           dout_o        : head entry (combinational from storage)
//           full_o/empty_o: occupancy flags
// ----------------------------------------------------------------------------
module icb_rr_arb_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)
         cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: validity is carried entirely by cnt_q.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/icb_rr_arb.sv
// ----------------------------------------------------------------------------
// icb_rr_arb
// Purpose : round-robin arbiter sharing one ICB slave port among M_NUM ICB
//           masters. Grant is held until the command handshakes, and the
//           owners of outstanding responses are kept in order for routing.
// Params  : M_NUM (2..4), OUTS_DEPTH (power of 2, >=2), WR_RSP (1: writes
//           are also tracked for a response)
// Ports   : clk, rst (async, active-high)
//           m_icb_cmd_*_i/_o : per-master command channels (flattened buses)
//           m_icb_rsp_*_i/_o : per-master response channels, rdata broadcast
//           s_icb_cmd_*/s_icb_rsp_* : shared slave-side port
//           stat_grant_cnt_o/stat_wait_cnt_o : per-master 32-bit counters
// Config  : `define ICB_ARB_STAT_EN to build the statistics counters;
//           otherwise the stat outputs are tied to zero.
// ----------------------------------------------------------------------------
module icb_rr_arb
   import icb_rr_arb_pkg::*;
#(
   parameter int M_NUM      = 2,
   parameter int OUTS_DEPTH = 4,
   parameter int WR_RSP     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [M_NUM-1:0]        m_icb_cmd_valid_i,
   output logic [M_NUM-1:0]        m_icb_cmd_ready_o,
   input  logic [M_NUM*32-1:0]     m_icb_cmd_addr_i,
   input  logic [M_NUM-1:0]        m_icb_cmd_read_i,
   input  logic [M_NUM*32-1:0]     m_icb_cmd_wdata_i,
   input  logic [M_NUM*4-1:0]      m_icb_cmd_wmask_i,
   output logic [M_NUM-1:0]        m_icb_rsp_valid_o,
   input  logic [M_NUM-1:0]        m_icb_rsp_ready_i,
   output logic [M_NUM-1:0]        m_icb_rsp_err_o,
   output logic [31:0]             m_icb_rsp_rdata_o,
   output logic                    s_icb_cmd_valid_o,
   input  logic                    s_icb_cmd_ready_i,
   output logic [31:0]             s_icb_cmd_addr_o,
   output logic                    s_icb_cmd_read_o,
   output logic [31:0]             s_icb_cmd_wdata_o,
   output logic [3:0]              s_icb_cmd_wmask_o,
   input  logic                    s_icb_rsp_valid_i,
   output logic                    s_icb_rsp_ready_o,
   input  logic                    s_icb_rsp_err_i,
   input  logic [31:0]             s_icb_rsp_rdata_i,
   output logic [M_NUM*32-1:0]     stat_grant_cnt_o,
   output logic [M_NUM*32-1:0]     stat_wait_cnt_o
);

   localparam int IW = idx_w(M_NUM);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          lock_q;
   logic [IW-1:0] lock_idx_q;
   logic [IW-1:0] pick_idx, gnt;
   logic          tracked, blocked, cmd_hs, push, pop;
   logic [IW-1:0] head;
   logic          fifo_full, fifo_empty;

   // First valid master at or after rr_ptr; scanning from the far end lets
   // the closest one win. With no requester the pointer itself is selected.
   always_comb begin
      pick_idx = rr_ptr_q;
      for (int k = M_NUM - 1; k >= 0; k--) begin
         int j;
         j = int'(rr_ptr_q) + k;
         if (j >= M_NUM) j = j - M_NUM;
         if (m_icb_cmd_valid_i[j]) pick_idx = IW'(j);
      end
   end

   // A stalled command keeps its owner even if an earlier master arrives.
   assign gnt     = lock_q ? lock_idx_q : pick_idx;
   assign tracked = m_icb_cmd_read_i[gnt] | (WR_RSP != 0);
   assign blocked = tracked & fifo_full;

   assign s_icb_cmd_valid_o = m_icb_cmd_valid_i[gnt] & ~blocked;
   assign s_icb_cmd_addr_o  = m_icb_cmd_addr_i[int'(gnt)*MEM_ADDR_W +: MEM_ADDR_W];
   assign s_icb_cmd_read_o  = m_icb_cmd_read_i[gnt];
   assign s_icb_cmd_wdata_o = m_icb_cmd_wdata_i[int'(gnt)*MEM_DATA_W +: MEM_DATA_W];
   assign s_icb_cmd_wmask_o = m_icb_cmd_wmask_i[int'(gnt)*ICB_MASK_W +: ICB_MASK_W];

   assign cmd_hs = s_icb_cmd_valid_o & s_icb_cmd_ready_i;
   assign push   = cmd_hs & tracked;

   always_comb begin
      m_icb_cmd_ready_o      = '0;
      m_icb_cmd_ready_o[gnt] = s_icb_cmd_ready_i & ~blocked;
   end

   always_comb begin
      if (int'(gnt) == M_NUM - 1) rr_ptr_d = '0;
      else                        rr_ptr_d = gnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (cmd_hs) begin
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= 1'b0;
      end else if (s_icb_cmd_valid_o) begin
         lock_q     <= 1'b1;
         lock_idx_q <= gnt;
      end
   end

   icb_rr_arb_fifo #(
      .W     (IW),
      .DEPTH (OUTS_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (gnt),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Response routing from the FIFO head; nothing is routed while empty.
   always_comb begin
      m_icb_rsp_valid_o = '0;
      m_icb_rsp_err_o   = '0;
      if (!fifo_empty) begin
         m_icb_rsp_valid_o[head] = s_icb_rsp_valid_i;
         m_icb_rsp_err_o[head]   = s_icb_rsp_err_i;
      end
   end

   assign s_icb_rsp_ready_o = ~fifo_empty & m_icb_rsp_ready_i[head];
   assign m_icb_rsp_rdata_o = s_icb_rsp_rdata_i;
   assign pop               = s_icb_rsp_valid_i & s_icb_rsp_ready_o;

`ifdef ICB_ARB_STAT_EN
   genvar gi;
   generate
      for (gi = 0; gi < M_NUM; gi++) begin : g_stat
         logic [31:0] grant_cnt_q, wait_cnt_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               grant_cnt_q <= '0;
               wait_cnt_q  <= '0;
            end else begin
               if (cmd_hs && int'(gnt) == gi)
                  grant_cnt_q <= grant_cnt_q + 1'b1;
               if (m_icb_cmd_valid_i[gi] && !m_icb_cmd_ready_o[gi])
                  wait_cnt_q <= wait_cnt_q + 1'b1;
            end
         end
         assign stat_grant_cnt_o[gi*32 +: 32] = grant_cnt_q;
         assign stat_wait_cnt_o[gi*32 +: 32]  = wait_cnt_q;
      end
   endgenerate
`else
   assign stat_grant_cnt_o = '0;
   assign stat_wait_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
   // A slave response with no recorded owner is a protocol violation.
   stray_rsp_a : assert property (@(posedge clk) disable iff (rst)
      !(s_icb_rsp_valid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_icb_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_icb_rr_arb
// Directed bench for icb_rr_arb (M_NUM=2, OUTS_DEPTH=4, WR_RSP=0). Expected
// grants and response owners are queued as stimulus is applied and popped
// as the design presents each command or response.
// ----------------------------------------------------------------------------
module tb_icb_rr_arb;

   logic        clk, rst;
   logic [1:0]  m_valid, m_cmd_ready, m_read, m_rsp_valid, m_rsp_ready, m_rsp_err;
   logic [63:0] m_addr, m_wdata;
   logic [7:0]  m_wmask;
   logic [31:0] m_rsp_rdata;
   logic        s_cmd_valid, s_cmd_ready, s_cmd_read;
   logic [31:0] s_cmd_addr, s_cmd_wdata;
   logic [3:0]  s_cmd_wmask;
   logic        s_rsp_valid, s_rsp_ready, s_rsp_err;
   logic [31:0] s_rsp_rdata;
   logic [63:0] stat_grant, stat_wait;

   int total = 0;
   int bad   = 0;
   int gnt_q[$];
   int rsp_q[$];

   icb_rr_arb #(.M_NUM(2), .OUTS_DEPTH(4), .WR_RSP(0)) dut (
      .clk               (clk),
      .rst               (rst),
      .m_icb_cmd_valid_i (m_valid),
      .m_icb_cmd_ready_o (m_cmd_ready),
      .m_icb_cmd_addr_i  (m_addr),
      .m_icb_cmd_read_i  (m_read),
      .m_icb_cmd_wdata_i (m_wdata),
      .m_icb_cmd_wmask_i (m_wmask),
      .m_icb_rsp_valid_o (m_rsp_valid),
      .m_icb_rsp_ready_i (m_rsp_ready),
      .m_icb_rsp_err_o   (m_rsp_err),
      .m_icb_rsp_rdata_o (m_rsp_rdata),
      .s_icb_cmd_valid_o (s_cmd_valid),
      .s_icb_cmd_ready_i (s_cmd_ready),
      .s_icb_cmd_addr_o  (s_cmd_addr),
      .s_icb_cmd_read_o  (s_cmd_read),
      .s_icb_cmd_wdata_o (s_cmd_wdata),
      .s_icb_cmd_wmask_o (s_cmd_wmask),
      .s_icb_rsp_valid_i (s_rsp_valid),
      .s_icb_rsp_ready_o (s_rsp_ready),
      .s_icb_rsp_err_i   (s_rsp_err),
      .s_icb_rsp_rdata_i (s_rsp_rdata),
      .stat_grant_cnt_o  (stat_grant),
      .stat_wait_cnt_o   (stat_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Command expected this cycle: owner from the grant queue.
   task automatic check_cmd(input string tag);
      int g;
      if (gnt_q.size() == 0) begin
         chk({tag, "_noexp"}, 64'(m_cmd_ready), 64'hDEAD);
         return;
      end
      g = gnt_q.pop_front();
      chk({tag, "_rdy"}, 64'(m_cmd_ready), 64'(1) << g);
      chk({tag, "_vld"}, 64'(s_cmd_valid), 64'(1));
      chk({tag, "_addr"}, 64'(s_cmd_addr), 64'(m_addr[g*32 +: 32]));
      chk({tag, "_rd"}, 64'(s_cmd_read), 64'(m_read[g]));
      chk({tag, "_wd"}, 64'(s_cmd_wdata), 64'(m_wdata[g*32 +: 32]));
      if (m_read[g]) rsp_q.push_back(g);
      $display("cmd  %s master=%0d addr=%08h read=%0b", tag, g, s_cmd_addr, s_cmd_read);
   endtask

   // Response expected this cycle: owner from the response queue.
   task automatic check_rsp(input string tag, input logic [31:0] data);
      int g;
      if (rsp_q.size() == 0) begin
         chk({tag, "_noexp"}, 64'(m_rsp_valid), 64'hDEAD);
         return;
      end
      g = rsp_q.pop_front();
      chk({tag, "_vld"}, 64'(m_rsp_valid), 64'(1) << g);
      chk({tag, "_data"}, 64'(m_rsp_rdata), 64'(data));
      chk({tag, "_srdy"}, 64'(s_rsp_ready), 64'(1));
      $display("rsp  %s master=%0d rdata=%08h", tag, g, m_rsp_rdata);
   endtask

   initial begin
      rst = 1'b1;
      m_valid = '0; m_read = 2'b11;
      m_addr  = {32'hB000_0004, 32'hA000_0000};
      m_wdata = {32'h2222_BBBB, 32'h1111_AAAA};
      m_wmask = 8'hFF;
      m_rsp_ready = '0;
      s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_err = 1'b0; s_rsp_rdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_scmd_vld", 64'(s_cmd_valid), 64'(0));
      chk("rst_mrsp_vld", 64'(m_rsp_valid), 64'(0));
      chk("rst_srsp_rdy", 64'(s_rsp_ready), 64'(0));
      chk("rst_mcmd_rdy", 64'(m_cmd_ready), 64'(0));
      chk("rst_stat_g", stat_grant, 64'(0));
      chk("rst_stat_w", stat_wait, 64'(0));
      tick();
      rst = 1'b0;

      // Both masters reading every cycle: grants alternate 0,1,0,1
      m_valid = 2'b11; s_cmd_ready = 1'b1;
      gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); check_cmd("t1"); tick();
      end
      m_valid = 2'b00;
      @(negedge clk);
      chk("t1_idle_vld", 64'(s_cmd_valid), 64'(0));
      chk("t1_idle_addr", 64'(s_cmd_addr), 64'(m_addr[31:0]));
      tick();

      // In-order response routing, data broadcast
      m_rsp_ready = 2'b11; s_rsp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s_rsp_rdata = 32'h11 * (k + 1);
         @(negedge clk); check_rsp("t4", s_rsp_rdata); tick();
      end
      s_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t4_empty_vld", 64'(m_rsp_valid), 64'(0));
      chk("t4_empty_rdy", 64'(s_rsp_ready), 64'(0));
      tick();

      // Grant lock: m1 stalled, m0 arrives later, m1 keeps the grant
      m_valid = 2'b10; s_cmd_ready = 1'b0;
      @(negedge clk);
      chk("t2_c1_vld", 64'(s_cmd_valid), 64'(1));
      chk("t2_c1_addr", 64'(s_cmd_addr), 64'(m_addr[63:32]));
      chk("t2_c1_rdy", 64'(m_cmd_ready), 64'(0));
      tick();
      m_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t2_lock_addr", 64'(s_cmd_addr), 64'(m_addr[63:32]));
         chk("t2_lock_rdy", 64'(m_cmd_ready), 64'(0));
         tick();
      end
      s_cmd_ready = 1'b1;
      gnt_q.push_back(1);
      @(negedge clk); check_cmd("t2_m1"); tick();
      m_valid = 2'b01;
      gnt_q.push_back(0);
      @(negedge clk); check_cmd("t2_m0"); tick();
      m_valid = 2'b00;

      // Head owner m1 not ready: slave rsp held, nothing popped
      s_rsp_valid = 1'b1; s_rsp_rdata = 32'h55; m_rsp_ready = 2'b01;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t5_hold_srdy", 64'(s_rsp_ready), 64'(0));
         chk("t5_hold_vld", 64'(m_rsp_valid), 64'(2'b10));
         tick();
      end
      m_rsp_ready = 2'b11; s_rsp_rdata = 32'h66;
      @(negedge clk); check_rsp("t5", s_rsp_rdata); tick();
      s_rsp_rdata = 32'h77;
      @(negedge clk); check_rsp("t5", s_rsp_rdata); tick();
      s_rsp_valid = 1'b0;

      // Fill the FIFO from m0, then the 5th read stalls
      m_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         gnt_q.push_back(0);
         @(negedge clk); check_cmd("t3_fill"); tick();
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t3_full_rdy", 64'(m_cmd_ready), 64'(0));
         chk("t3_full_vld", 64'(s_cmd_valid), 64'(0));
         tick();
      end
      // An untracked write still passes while full
      m_read = 2'b10;
      gnt_q.push_back(0);
      @(negedge clk); check_cmd("t3_wr"); tick();
      // Pop in the same cycle does not free a slot for a push
      m_read = 2'b11; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h81;
      @(negedge clk);
      chk("t3_pushblk", 64'(m_cmd_ready), 64'(0));
      check_rsp("t3_pop", s_rsp_rdata);
      tick();
      s_rsp_valid = 1'b0;
      gnt_q.push_back(0);
      @(negedge clk); check_cmd("t3_after"); tick();
      m_valid = 2'b00;
      s_rsp_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         s_rsp_rdata = 32'h90 + k;
         @(negedge clk); check_rsp("t3_drain", s_rsp_rdata); tick();
      end
      s_rsp_valid = 1'b0;

      // Reset with two reads outstanding and rr_ptr=1
      rst = 1'b1;
      rsp_q.delete(); gnt_q.delete();
      @(negedge clk);
      chk("t6_rst_vld", 64'(m_rsp_valid), 64'(0));
      chk("t6_rst_srdy", 64'(s_rsp_ready), 64'(0));
      chk("t6_stat_g", stat_grant, 64'(0));
      chk("t6_stat_w", stat_wait, 64'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_post_srdy", 64'(s_rsp_ready), 64'(0));
      chk("t6_post_vld", 64'(m_rsp_valid), 64'(0));
      tick();
      m_valid = 2'b11;
      gnt_q.push_back(0);
      @(negedge clk); check_cmd("t6_ptr0"); tick();
      m_valid = 2'b00;
      @(negedge clk);
      chk("t6_leftover_g", 64'(gnt_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
